// File: rtl/csa_word_sequencer.sv
// Byte-serial word adder: one shared 8-bit conditional-sum adder, LSB byte first.
// Optional subtract support is compiled in with `define CSA_SEQ_SUB_EN.

module conditional_sum_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       c0,
    output logic [7:0] Sum,
    output logic       c8
);
    genvar gi, gj;

    // Each level doubles the group size; s0/k0 assume carry-in 0, s1/k1 assume carry-in 1.
    generate
        for (gi = 0; gi < 4; gi++) begin : lvl
            localparam int G  = 1 << gi;
            localparam int NG = 8 >> gi;
            logic [7:0]    s0;
            logic [7:0]    s1;
            logic [NG-1:0] k0;
            logic [NG-1:0] k1;

            if (gi == 0) begin : base
                assign s0 = x ^ y;
                assign s1 = ~(x ^ y);
                assign k0 = x & y;
                assign k1 = x | y;
            end else begin : merge
                for (gj = 0; gj < NG; gj++) begin : grp
                    localparam int H  = G / 2;
                    localparam int LO = gj * G;
                    localparam int HI = gj * G + H;

                    assign s0[LO +: H] = lvl[gi-1].s0[LO +: H];
                    assign s1[LO +: H] = lvl[gi-1].s1[LO +: H];
                    assign s0[HI +: H] = lvl[gi-1].k0[2*gj] ? lvl[gi-1].s1[HI +: H]
                                                            : lvl[gi-1].s0[HI +: H];
                    assign s1[HI +: H] = lvl[gi-1].k1[2*gj] ? lvl[gi-1].s1[HI +: H]
                                                            : lvl[gi-1].s0[HI +: H];
                    assign k0[gj] = lvl[gi-1].k0[2*gj] ? lvl[gi-1].k1[2*gj+1]
                                                       : lvl[gi-1].k0[2*gj+1];
                    assign k1[gj] = lvl[gi-1].k1[2*gj] ? lvl[gi-1].k1[2*gj+1]
                                                       : lvl[gi-1].k0[2*gj+1];
                end
            end
        end
    endgenerate

    assign Sum = c0 ? lvl[3].s1    : lvl[3].s0;
    assign c8  = c0 ? lvl[3].k1[0] : lvl[3].k0[0];
endmodule

module csa_word_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef CSA_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;

    logic [7:0]     x_byte;
    logic [7:0]     y_byte;
    logic [7:0]     add_sum;
    logic           add_c8;
    logic           start_carry;

`ifdef CSA_SEQ_SUB_EN
    logic           sub_q, sub_d;

    // Subtraction is A + ~B + 1; the caller's cin is irrelevant then.
    assign y_byte      = b_q[{idx_q, 3'b000} +: 8] ^ {8{sub_q}};
    assign start_carry = sub ? 1'b1 : cin;
`else
    assign y_byte      = b_q[{idx_q, 3'b000} +: 8];
    assign start_carry = cin;
`endif

    assign x_byte = a_q[{idx_q, 3'b000} +: 8];

    conditional_sum_adder u_adder (
        .x   (x_byte),
        .y   (y_byte),
        .c0  (carry_q),
        .Sum (add_sum),
        .c8  (add_c8)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CSA_SEQ_SUB_EN
        sub_d   = sub_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = start_carry;
                    idx_d   = '0;
`ifdef CSA_SEQ_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                res_d[{idx_q, 3'b000} +: 8] = add_sum;
                carry_d = add_c8;
                if (idx_q == LAST_IDX) begin
                    // Publish includes the byte being written on this same edge.
                    sum_d   = res_d;
                    cout_d  = add_c8;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CSA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CSA_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_csa_word_sequencer.sv
// Directed bench for csa_word_sequencer (NBYTES=4): arithmetic, handshake timing, reset abort.
// Subtract vectors run only when CSA_SEQ_SUB_EN is defined.

module tb_csa_word_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef CSA_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_sum;
    logic        last_cout;

    csa_word_sequencer #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CSA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge accepts the request.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv,
                            input logic cv, input logic sv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
`ifdef CSA_SEQ_SUB_EN
        sub   = sv;
`else
        if (sv) $display("note: sub requested without subtract support");
`endif
    endtask

    // Walks the four RUN cycles and the DONE cycle, returning at the DONE-cycle negedge.
    task automatic finish_op(input string name, input logic [31:0] exp_sum,
                             input logic exp_cout, input logic inject);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (inject && n == 1) begin
                start = 1'b1;
                a     = 32'hFFFF_FFFF;
                b     = 32'hFFFF_FFFF;
                cin   = 1'b1;
            end
            if (inject && n == 2) start = 1'b0;
            chk({name, "_busy_run"}, busy, 1);
            chk({name, "_done_run"}, done, 0);
            chk({name, "_sum_hold"}, sum, last_sum);
            chk({name, "_cout_hold"}, cout, last_cout);
        end
        @(negedge clk);
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_done"}, busy, 0);
        chk({name, "_sum"}, sum, exp_sum);
        chk({name, "_cout"}, cout, exp_cout);
        $display("op %s: sum=0x%08h cout=%0d (expected 0x%08h %0d)", name, sum, cout, exp_sum, exp_cout);
        last_sum  = exp_sum;
        last_cout = exp_cout;
    endtask

    task automatic one_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic sv, input logic [31:0] exp_sum,
                          input logic exp_cout);
        @(negedge clk);
        start_op(av, bv, cv, sv);
        finish_op(name, exp_sum, exp_cout, 1'b0);
        @(negedge clk);
        chk({name, "_done_drop"}, done, 0);
        chk({name, "_idle"}, busy, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        last_sum  = '0;
        last_cout = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0;

        one_op("add_small", 32'h0000_000C, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_0011, 1'b0);
        one_op("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        one_op("mixed_cin", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0);
        one_op("msb_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        one_op("byte_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0);
        one_op("cin_only", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);

        // start during RUN must not disturb the operation in flight
        @(negedge clk);
        start_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        finish_op("run_start_ignored", 32'h3333_3333, 1'b0, 1'b1);
        @(negedge clk);
        chk("ignored_no_rerun", busy, 0);

        // start held in the DONE cycle is accepted immediately
        @(negedge clk);
        start_op(32'h0000_000C, 32'h0000_0005, 1'b0, 1'b0);
        finish_op("b2b_first", 32'h0000_0011, 1'b0, 1'b0);
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        finish_op("b2b_second", 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_done_drop", done, 0);

        // reset in the second RUN cycle aborts without a done pulse
        @(negedge clk);
        start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        last_sum  = '0;
        last_cout = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        $display("op abort: reset during RUN, outputs cleared");
        one_op("after_abort", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);

`ifdef CSA_SEQ_SUB_EN
        one_op("sub_basic", 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_000F, 1'b1);
        one_op("sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        one_op("sub_off_add", 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0012, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/csa_word_sequencer.md
# csa_word_sequencer

Multi-cycle word adder that computes an NBYTES-byte sum using one shared 8-bit `conditional_sum_adder` instance, one byte per clock, least-significant byte first. The carry is chained through a register between bytes. It sits between a register-file/ALU control front end and the combinational adder. It sequences operand bytes into the adder, collects the result, and reports completion with a start/busy/done handshake.

## Interface
Parameters:
- `NBYTES`, default 4: operand width in bytes (word width W = 8*NBYTES); legal range 2..16.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a new operation; sampled only while `busy`=0.
- `a` in W: operand A; latched when `start` is accepted.
- `b` in W: operand B; latched when `start` is accepted.
- `cin` in 1: initial carry-in; latched when `start` is accepted.
- `sub` in 1: subtract select; latched when `start` is accepted. Present only with `CSA_SEQ_SUB_EN`.
- `busy` out 1: high while bytes are being processed.
- `done` out 1: one-cycle pulse when a new result is published.
- `sum` out W: published result; holds its value until the next publish.
- `cout` out 1: published final carry-out; holds its value until the next publish.

## Operation
- States: IDLE, RUN, DONE.
- Reset (any state) -> IDLE. Reset values:
  - Outputs: `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - Internal: byte index=0, carry register=0, working registers=0.
- IDLE or DONE with `start`=1:
  - Latch `a`, `b` into working registers.
  - Carry register <= `cin`; index <= 0.
  - Go to RUN.
- IDLE with `start`=0: stay. DONE with `start`=0: go to IDLE.
- RUN, each cycle:
  - Drive the adder with `x`=byte[index] of A, `y`=byte[index] of B, `c0`=carry register.
  - Write adder `Sum` into byte[index] of the working result.
  - Carry register <= adder `c8`; index <= index+1.
  - On the cycle where index = NBYTES-1:
    - Publish: `sum` <= full working result including the final byte; `cout` <= that byte's `c8`.
    - Go to DONE; index wraps to 0.
- `start` while in RUN is ignored: no queuing, operands unaffected.
- `sum`/`cout` never show partial results; they change only on the publish edge (or on reset).
- Arithmetic is modulo 2^W; overflow appears only on `cout`.
- Reset during RUN aborts the operation: no `done` pulse, and published outputs return to 0.

## Timing
- `start` accepted at edge E0 -> `busy`=1 for cycles E0..E(NBYTES-1).
- Publish at edge E(NBYTES); `done`=1 and `busy`=0 during the cycle following E(NBYTES).
- Latency from start acceptance to `done` high: NBYTES cycles.
- Back-to-back: `start` high in the DONE cycle is accepted, and `done` pulses again NBYTES cycles later. Peak throughput is one result per NBYTES cycles.
- The adder path is combinational within one cycle: byte operand mux -> `conditional_sum_adder` -> result/carry registers.
- `done` is never high for two consecutive cycles.

## Configuration
- Macro `CSA_SEQ_SUB_EN`.
- Defined:
  - `sub` port exists.
  - When latched `sub`=1: every B byte is inverted before the adder, the initial carry is forced to 1, and `cin` is ignored. Result = A-B mod 2^W.
  - `cout`=1 means no borrow; `cout`=0 means borrow.
  - `sub`=0 behaves as plain addition.
- Undefined: no `sub` port; addition only. Gate count and timing match the add path.

## Test plan
All scenarios use NBYTES=4.
1. A=0x0000000C, B=0x00000005, `cin`=0 -> `sum`=0x00000011, `cout`=0. `done` rises exactly 4 cycles after start acceptance; `busy` is high for 4 cycles.
2. A=0xFFFFFFFF, B=0x00000001, `cin`=0 -> `sum`=0x00000000, `cout`=1 (carry chained through all bytes).
3. A=0x12345678, B=0x9ABCDEF0, `cin`=1 -> `sum`=0xACF13569, `cout`=0. `sum` keeps its previous value throughout RUN.
4. Handshake rules:
   - `start` pulsed with new operands during RUN -> ignored; the result matches the original operands.
   - `start` held in the DONE cycle -> accepted; the second `done` arrives 4 cycles later with the new result.
5. `rst` asserted in the 2nd RUN cycle -> the next cycle shows `busy`=0, `sum`=0, `cout`=0, and `done` never pulses. A subsequent start completes normally.
6. `CSA_SEQ_SUB_EN` defined:
   - `sub`=1, A=0x00000010, B=0x00000001 -> `sum`=0x0000000F, `cout`=1.
   - `sub`=1, A=0, B=1 -> `sum`=0xFFFFFFFF, `cout`=0.
